// File: rtl/wave_seq_ctrl_if.sv
// Host-side bundle for the segment sequencer: table writes, playback
// control and the generator-facing outputs.
interface wave_seq_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic [2:0]           cfg_wave_sel;
    logic [7:0]           cfg_freq;
    logic signed [7:0]    cfg_amp;
    logic [7:0]           cfg_duty;
    logic [DUR_W-1:0]     cfg_dur;
    logic [NW-1:0]        num_seg;
    logic                 loop_en;
    logic                 start;
    logic                 stop;

    logic [2:0]           wave_sel;
    logic [7:0]           freq;
    logic signed [7:0]    wave_amp;
    logic [7:0]           duty_cycle;
    logic                 busy;
    logic [AW-1:0]        seg_idx;
    logic                 seg_strobe;
    logic                 done;
    logic [7:0]           pass_cnt;

    modport master (
        output cfg_we, cfg_addr, cfg_wave_sel, cfg_freq, cfg_amp, cfg_duty,
               cfg_dur, num_seg, loop_en, start, stop,
        input  wave_sel, freq, wave_amp, duty_cycle, busy, seg_idx,
               seg_strobe, done, pass_cnt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wave_sel, cfg_freq, cfg_amp, cfg_duty,
               cfg_dur, num_seg, loop_en, start, stop,
        output wave_sel, freq, wave_amp, duty_cycle, busy, seg_idx,
               seg_strobe, done, pass_cnt
    );
endinterface

// File: rtl/wave_seq_ctrl.sv
// Segment sequencer: plays a programmable table of waveform settings, each
// held for a number of cycles, once or looped, into the waveform generator.
module wave_seq_ctrl #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    wave_seq_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    typedef enum logic [2:0] {IDLE, FETCH, APPLY, RUN, DONE} state_t;

    typedef struct packed {
        logic [2:0]       wave_sel;
        logic [7:0]       freq;
        logic [7:0]       amp;
        logic [7:0]       duty;
        logic [DUR_W-1:0] dur;
    } seg_t;

    localparam seg_t SEG_RST = {3'd0, 8'd0, 8'd0, 8'd128, {DUR_W{1'b0}}};

    state_t           state, nxt;
    seg_t             tbl [DEPTH];
    seg_t             fetch_q;
    logic [AW-1:0]    seg_idx_q;
    logic [NW-1:0]    num_cap;
    logic             loop_cap;
    logic [7:0]       pass_q;
    logic [DUR_W-1:0] remaining;
    logic [2:0]       ws_q;
    logic [7:0]       freq_q;
    logic [7:0]       amp_q;
    logic [7:0]       duty_q;
    logic             strobe_q;
    logic             done_q;

    logic             accept;
    logic             abort;
    logic             last_seg;
    logic             seg_end;
    logic [NW-1:0]    num_clamp;

    assign abort     = bus.stop && (state != IDLE);
    assign last_seg  = ({1'b0, seg_idx_q} == (num_cap - NW'(1)));
    assign seg_end   = (state == RUN) && (remaining == DUR_W'(1));
    assign num_clamp = (bus.num_seg > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_seg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop && (bus.num_seg != '0)) begin
                    nxt    = FETCH;
                    accept = 1'b1;
                end
            end
            FETCH: nxt = APPLY;
            APPLY: nxt = RUN;
            RUN: begin
                if (remaining == DUR_W'(1))
                    nxt = (last_seg && !loop_cap) ? DONE : FETCH;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // stop wins over everything, including the DONE pulse
        if (abort) nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= SEG_RST;
            fetch_q   <= SEG_RST;
            seg_idx_q <= '0;
            num_cap   <= '0;
            loop_cap  <= 1'b0;
            pass_q    <= '0;
            remaining <= '0;
            ws_q      <= '0;
            freq_q    <= '0;
            amp_q     <= '0;
            duty_q    <= 8'd128;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;

            // Table writes are accepted in every state; a same-cycle fetch sees old data.
            if (bus.cfg_we)
                tbl[bus.cfg_addr] <= {bus.cfg_wave_sel, bus.cfg_freq, bus.cfg_amp,
                                      bus.cfg_duty, bus.cfg_dur};

            if (abort) begin
                amp_q <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            num_cap   <= num_clamp;
                            loop_cap  <= bus.loop_en;
                            seg_idx_q <= '0;
                            pass_q    <= '0;
                        end
                    end
                    FETCH: fetch_q <= tbl[seg_idx_q];
                    APPLY: begin
                        ws_q      <= fetch_q.wave_sel;
                        freq_q    <= fetch_q.freq;
                        amp_q     <= fetch_q.amp;
                        duty_q    <= fetch_q.duty;
                        remaining <= (fetch_q.dur == '0) ? DUR_W'(1) : fetch_q.dur;
                        strobe_q  <= 1'b1;
                    end
                    RUN: begin
                        remaining <= remaining - DUR_W'(1);
                        if (seg_end) begin
                            if (!last_seg) begin
                                seg_idx_q <= seg_idx_q + AW'(1);
                            end else begin
                                if (pass_q != 8'hFF) pass_q <= pass_q + 8'd1;
                                if (loop_cap) seg_idx_q <= '0;
                            end
                        end
                    end
                    DONE: begin
                        amp_q  <= '0;
                        done_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.wave_sel   = ws_q;
    assign bus.freq       = freq_q;
    assign bus.wave_amp   = amp_q;
    assign bus.duty_cycle = duty_q;
    assign bus.busy       = (state != IDLE);
    assign bus.seg_idx    = seg_idx_q;
    assign bus.seg_strobe = strobe_q;
    assign bus.done       = done_q;
    assign bus.pass_cnt   = pass_q;
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Randomized scoreboard bench for wave_seq_ctrl: a segment-list model
// predicts every seg_strobe / done event with its edge number and payload.
module tb_wave_seq_ctrl;
    localparam int DEPTH = 8;
    localparam int DUR_W = 16;
    localparam int AW    = 3;
    localparam int NW    = 4;
    localparam int BIG   = 1 << 30;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;

    wave_seq_ctrl_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

    wave_seq_ctrl #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit                is_done;
        int                e;
        int                idx;
        logic [2:0]        ws;
        logic [7:0]        fr;
        logic signed [7:0] am;
        logic [7:0]        du;
        int                pc;
    } ev_t;

    ev_t q[$];

    logic [2:0]        m_ws [DEPTH];
    logic [7:0]        m_fr [DEPTH];
    logic signed [7:0] m_am [DEPTH];
    logic [7:0]        m_du [DEPTH];
    int                m_dur[DEPTH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected event list: segment k of a pass is applied 2 edges after the
    // previous one ended; segment length is max(dur,1); events at or after
    // 'limit' (a stop edge) never happen.
    task automatic gen(int s, int n, bit lp, int limit);
        int  t, p, d;
        bit  fin;
        ev_t ev;
        if (n > DEPTH) n = DEPTH;
        t = s + 2;
        p = 0;
        fin = (n == 0);
        while (!fin) begin
            for (int k = 0; k < n && !fin; k++) begin
                if (t >= limit) begin
                    fin = 1'b1;
                end else begin
                    ev.is_done = 1'b0;
                    ev.e  = t;
                    ev.idx = k;
                    ev.ws = m_ws[k];
                    ev.fr = m_fr[k];
                    ev.am = m_am[k];
                    ev.du = m_du[k];
                    ev.pc = (p > 255) ? 255 : p;
                    q.push_back(ev);
                    d = (m_dur[k] == 0) ? 1 : m_dur[k];
                    if (k == n - 1) begin
                        p++;
                        if (!lp) begin
                            if (t + d + 1 < limit) begin
                                ev.is_done = 1'b1;
                                ev.e  = t + d + 1;
                                ev.pc = p;
                                q.push_back(ev);
                            end
                            fin = 1'b1;
                        end
                    end
                    t += d + 2;
                end
            end
        end
    endtask

    // Monitor: pops an expectation on every strobe/done; between strobes the
    // generator outputs must hold the last applied segment.
    ev_t cur;
    bit  have_cur;
    initial have_cur = 1'b0;
    always @(negedge clk) begin
        ev_t ev;
        if (rst) begin
            if (bus.seg_strobe || bus.done) begin
                if (q.size() == 0) begin
                    chk(bus.done ? "unexpected_done" : "unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    ev = q.pop_front();
                    chk("event_kind", 32'(bus.done), 32'(ev.is_done));
                    chk("event_cycle", 32'(cyc), 32'(ev.e));
                    chk("pass_cnt", 32'(bus.pass_cnt), 32'(ev.pc));
                    if (!ev.is_done) begin
                        chk("seg_idx", 32'(bus.seg_idx), 32'(ev.idx));
                        chk("wave_sel", 32'(bus.wave_sel), 32'(ev.ws));
                        chk("freq", 32'(bus.freq), 32'(ev.fr));
                        chk("wave_amp", 32'(bus.wave_amp), 32'(ev.am));
                        chk("duty", 32'(bus.duty_cycle), 32'(ev.du));
                        cur = ev;
                        have_cur = 1'b1;
                    end else begin
                        chk("done_amp0", 32'(bus.wave_amp), 32'd0);
                        chk("done_busy0", 32'(bus.busy), 32'd0);
                    end
                end
            end else if (have_cur && bus.busy) begin
                chk("hold_wave_sel", 32'(bus.wave_sel), 32'(cur.ws));
                chk("hold_freq", 32'(bus.freq), 32'(cur.fr));
                chk("hold_amp", 32'(bus.wave_amp), 32'(cur.am));
                chk("hold_duty", 32'(bus.duty_cycle), 32'(cur.du));
            end
            if (!bus.busy) have_cur = 1'b0;
        end else begin
            have_cur = 1'b0;
        end
    end

    task automatic mwr(int a, int ws, int fr, int am, int du, int dur);
        m_ws[a] = 3'(ws);  m_fr[a] = 8'(fr); m_am[a] = 8'(am);
        m_du[a] = 8'(du);  m_dur[a] = dur;
    endtask

    task automatic dwr(int a, int ws, int fr, int am, int du, int dur);
        bus.cfg_we = 1'b1;       bus.cfg_addr = AW'(a);
        bus.cfg_wave_sel = 3'(ws); bus.cfg_freq = 8'(fr); bus.cfg_amp = 8'(am);
        bus.cfg_duty = 8'(du);   bus.cfg_dur = DUR_W'(dur);
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic wr(int a, int ws, int fr, int am, int du, int dur);
        mwr(a, ws, fr, am, du, dur);
        dwr(a, ws, fr, am, du, dur);
    endtask

    task automatic wr_rand(int a);
        wr(a, $urandom_range(0, 4), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 6));
    endtask

    task automatic go(int n, bit lp, int lim_off, output int s);
        bus.num_seg = NW'(n);
        bus.loop_en = lp;
        bus.start   = 1'b1;
        s = cyc + 1;
        gen(s, n, lp, (lim_off >= BIG) ? BIG : s + lim_off);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() != 0 && b < 5000) begin
            @(negedge clk);
            b++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_wave_sel"}, 32'(bus.wave_sel), 32'd0);
        chk({tag, "_freq"}, 32'(bus.freq), 32'd0);
        chk({tag, "_amp"}, 32'(bus.wave_amp), 32'd0);
        chk({tag, "_duty"}, 32'(bus.duty_cycle), 32'd128);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_seg_idx"}, 32'(bus.seg_idx), 32'd0);
        chk({tag, "_strobe"}, 32'(bus.seg_strobe), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_pass"}, 32'(bus.pass_cnt), 32'd0);
    endtask

    initial begin
        int s;
        int n;
        errors = 0;
        checks = 0;
        rst = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wave_sel = '0; bus.cfg_freq = '0;
        bus.cfg_amp = '0;  bus.cfg_duty = '0; bus.cfg_dur = '0;
        bus.num_seg = '0;  bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        for (int i = 0; i < DEPTH; i++) mwr(i, 0, 0, 0, 128, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst");

        // single pass, with an ignored start/num_seg/loop_en change mid-run
        wr(0, 0, 4, 50, 64, 10);
        wr(1, 2, 8, -20, 200, 5);
        go(2, 1'b0, BIG, s);
        wait_until(s + 6);
        bus.num_seg = '0; bus.loop_en = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        chk("single_pass_cnt", 32'(bus.pass_cnt), 32'd1);
        chk("single_busy", 32'(bus.busy), 32'd0);
        chk("single_amp", 32'(bus.wave_amp), 32'd0);

        // loop, stop during entry 0 RUN of the 4th pass
        go(2, 1'b1, 62, s);
        wait_until(s + 61);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("stop_busy", 32'(bus.busy), 32'd0);
        chk("stop_amp", 32'(bus.wave_amp), 32'd0);
        chk("stop_pass", 32'(bus.pass_cnt), 32'd3);
        chk("stop_hold_freq", 32'(bus.freq), 32'd4);
        repeat (25) @(negedge clk);
        drain();

        // num_seg=0 start is ignored
        go(0, 1'b0, BIG, s);
        repeat (3) @(negedge clk);
        chk("nseg0_busy", 32'(bus.busy), 32'd0);

        // start and stop together from IDLE
        bus.num_seg = NW'(2); bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("startstop_busy", 32'(bus.busy), 32'd0);
        repeat (4) @(negedge clk);
        drain();

        // dur=0 behaves as dur=1
        wr(0, 3, 16, 100, 10, 0);
        go(2, 1'b0, BIG, s);
        drain();

        // write to entry 0 on its own fetch edge: old data is played
        wr(0, 1, 9, 33, 77, 3);
        go(1, 1'b0, BIG, s);
        dwr(0, 4, 99, -7, 5, 2);
        mwr(0, 4, 99, -7, 5, 2);
        drain();
        go(1, 1'b0, BIG, s);
        drain();

        // entry 1 rewritten while entry 0 is running
        wr(0, 0, 4, 50, 64, 10);
        mwr(1, 4, 77, 60, 90, 4);
        go(2, 1'b0, BIG, s);
        wait_until(s + 5);
        dwr(1, 4, 77, 60, 90, 4);
        drain();

        // num_seg beyond DEPTH clamps to all entries
        for (int k = 0; k < DEPTH; k++) wr_rand(k);
        go(15, 1'b0, BIG, s);
        drain();

        repeat (4) begin
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) wr_rand(k);
            go(n, 1'b0, BIG, s);
            drain();
        end

        // pass counter saturation: 300 passes of a 3-cycle loop
        wr(0, 1, 3, 5, 7, 1);
        go(1, 1'b1, 2 + 900, s);
        wait_until(s + 901);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk("sat_pass", 32'(bus.pass_cnt), 32'd255);
        chk("sat_busy", 32'(bus.busy), 32'd0);
        drain();

        // async reset mid-RUN clears outputs and the table
        wr(0, 2, 20, 40, 60, 20);
        go(1, 1'b0, BIG, s);
        wait_until(s + 6);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals("async");
        q.delete();
        for (int i = 0; i < DEPTH; i++) mwr(i, 0, 0, 0, 128, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("post");
        go(1, 1'b0, BIG, s);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
